mem_access_unit: RTL and testbench

- Load/store front end between the pipeline's MEM-stage request and the 64-bit word-addressed data memory.
- Converts byte-addressed LDUR/STUR-family requests into data memory accesses. Sizes: byte, half, word and double.
- Performs sub-word extraction with sign/zero extension, read-modify-write for partial stores, and alignment checking.
- Presents a single-outstanding valid/ready request interface and a one-cycle response pulse.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 118 +++++++++++
 tb/tb_mem_access_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states and lane geometry.
package mem_access_pkg;

  localparam int WORD_BYTES = 8;
  localparam int LANE_W     = 3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // Natural alignment: the lane must be a multiple of the access size in bytes.
  function automatic logic misaligned(input logic [LANE_W-1:0] lane, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one 64-bit word: extended load extraction and read-modify-write merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [63:0]       rdbuf,
  input  logic [63:0]       wdata,
  output logic [63:0]       load_data,
  output logic [63:0]       store_data,
  output logic [63:0]       mask
);

  logic [63:0] size_mask;
  logic [63:0] raw;
  logic [5:0]  shamt;
  logic        sbit;

  assign shamt = {lane, 3'b000};

  always_comb begin
    size_mask = '1;
    sbit      = raw[63];
    case (size)
      SZ_B: begin size_mask = 64'h0000_0000_0000_00FF; sbit = raw[7];  end
      SZ_H: begin size_mask = 64'h0000_0000_0000_FFFF; sbit = raw[15]; end
      SZ_W: begin size_mask = 64'h0000_0000_FFFF_FFFF; sbit = raw[31]; end
      default: begin size_mask = '1; sbit = raw[63]; end
    endcase
  end

  assign raw        = (rdbuf >> shamt) & size_mask;
  assign load_data  = (sign && sbit) ? (raw | ~size_mask) : raw;
  assign mask       = size_mask << shamt;
  // A double access is always lane 0, so the merge degenerates to wdata.
  assign store_data = (rdbuf & ~mask) | ((wdata << shamt) & mask);

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front end to a 64-bit word-addressed data memory.
// Optional range check enabled by defining MEM_ACCESS_UNIT_BOUNDS_CHECK_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and resp_valid is a single-cycle pulse with no backpressure.

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RD   = RD;
  localparam logic [1:0] S_WR   = WR;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              signed_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdbuf;
  logic              err_q;

  logic              oob;
  logic              req_err;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] lane_mask;

`ifdef MEM_ACCESS_UNIT_BOUNDS_CHECK_EN
  assign oob = {{LANE_W{1'b0}}, req_addr[ADDR_W-1:LANE_W]} >= ADDR_W'(MEM_WORDS);
`else
  assign oob = 1'b0;
`endif

  assign req_err = oob || misaligned(req_addr[LANE_W-1:0], req_size);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdbuf    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            if (req_err)                         state <= S_RESP;
            else if (req_write && req_size == SZ_D) state <= S_WR;
            else                                 state <= S_RD;
          end
        end
        S_RD: begin
          rdbuf <= mem_readData;
          state <= write_q ? S_WR : S_RESP;
        end
        S_WR:    state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_lane_align u_align (
    .lane       (addr_q[LANE_W-1:0]),
    .size       (size_q),
    .sign       (signed_q),
    .rdbuf      (rdbuf),
    .wdata      (wdata_q),
    .load_data  (load_word),
    .store_data (store_word),
    .mask       (lane_mask)
  );

  // The address stays on the latched word index after the access; only strobes drop.
  assign mem_address   = {{LANE_W{1'b0}}, addr_q[ADDR_W-1:LANE_W]};
  assign mem_read      = (state == S_RD);
  assign mem_write     = (state == S_WR);
  assign mem_writeData = mem_write ? (store_word & ((lane_mask | ~lane_mask))) : '0;
  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign resp_error    = resp_valid && err_q;
  assign resp_rdata    = (resp_valid && !err_q && !write_q) ? load_word : '0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small behavioural word memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_writeData;
  logic [63:0] mem_readData;
  logic [1:0]  dbg_state;

  logic [63:0] mem [0:7];
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_W(64), .DATA_W(64), .MEM_WORDS(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_readData(mem_readData), .dbg_state(dbg_state)
  );

  assign mem_readData = (mem_address < 64'd8) ? mem[mem_address[2:0]] : 64'd0;

  always @(posedge clock)
    if (mem_write && mem_address < 64'd8) mem[mem_address[2:0]] <= mem_writeData;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to its response, checking timing and memory traffic.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input int exp_rd, input int exp_wr, input logic [63:0] exp_wdata);
    logic [63:0] rdata, wdat, acc_addr;
    logic        err, done;
    int          lat, n_rd, n_wr, n_both, n_rdy;
    rdata = '0; wdat = '0; acc_addr = '0; err = 1'b0; done = 1'b0;
    n_rd = 0; n_wr = 0; n_both = 0; n_rdy = 0;
    @(negedge clock);
    check({tag, ":ready_idle"}, 64'(req_ready), 64'd1);
    req_write = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    exp_q.push_back(exp_rdata);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat <= 10) begin
      if (mem_read)  begin n_rd++; acc_addr = mem_address; end
      if (mem_write) begin n_wr++; wdat = mem_writeData; acc_addr = mem_address; end
      if (mem_read && mem_write) n_both++;
      if (req_ready) n_rdy++;
      if (resp_valid) begin
        done = 1'b1; rdata = resp_rdata; err = resp_error;
      end else begin
        @(negedge clock);
        lat++;
      end
    end
    check({tag, ":responded"}, 64'(done), 64'd1);
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ":error"}, 64'(err), 64'(exp_err));
    check({tag, ":rdata"}, rdata, exp_q.pop_front());
    check({tag, ":reads"}, 64'(n_rd), 64'(exp_rd));
    check({tag, ":writes"}, 64'(n_wr), 64'(exp_wr));
    check({tag, ":rd_wr_overlap"}, 64'(n_both), 64'd0);
    check({tag, ":ready_busy"}, 64'(n_rdy), 64'd0);
    if (n_wr > 0) check({tag, ":wdata"}, wdat, exp_wdata);
    if (n_rd + n_wr > 0) check({tag, ":mem_addr"}, acc_addr, addr >> 3);
    @(negedge clock);
    check({tag, ":ready_after"}, 64'(req_ready), 64'd1);
    check({tag, ":strobes_after"}, 64'({mem_read, mem_write, resp_valid}), 64'd0);
  endtask

  initial begin
    int n_w, n_v;
    for (int i = 0; i < 8; i++) mem[i] = 64'h0;
    mem[0] = 64'h0000_0000_0000_80FF;
    mem[1] = 64'h1122_3344_5566_7788;
    mem[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    mem[5] = 64'h5555_0000_5555_0000;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset:ready", 64'(req_ready), 64'd1);
    check("reset:state", 64'(dbg_state), 64'(IDLE));
    check("reset:strobes", 64'({resp_valid, resp_error, mem_read, mem_write}), 64'd0);
    check("reset:rdata", resp_rdata, 64'd0);
    check("reset:mem_addr", mem_address, 64'd0);
    check("reset:mem_wdata", mem_writeData, 64'd0);

    run_req("ld_d", 1'b0, SZ_D, 1'b0, 64'h08, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 2, 1, 0, 64'h0);
    run_req("ld_b_s", 1'b0, SZ_B, 1'b1, 64'h01, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1, 0, 64'h0);
    run_req("ld_b_u", 1'b0, SZ_B, 1'b0, 64'h01, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 2, 1, 0, 64'h0);
    run_req("ld_h_s", 1'b0, SZ_H, 1'b1, 64'h00, 64'h0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 2, 1, 0, 64'h0);
    run_req("st_h", 1'b1, SZ_H, 1'b0, 64'h14, 64'h1234, 64'h0, 1'b0, 3, 1, 1, 64'hAAAA_1234_AAAA_AAAA);
    check("st_h:mem2", mem[2], 64'hAAAA_1234_AAAA_AAAA);
    run_req("ld_h_back", 1'b0, SZ_H, 1'b1, 64'h14, 64'h0, 64'h0000_0000_0000_1234, 1'b0, 2, 1, 0, 64'h0);
    run_req("st_w", 1'b1, SZ_W, 1'b0, 64'h04, 64'hCAFE_BABE, 64'h0, 1'b0, 3, 1, 1, 64'hCAFE_BABE_0000_80FF);
    run_req("ld_w_s", 1'b0, SZ_W, 1'b1, 64'h04, 64'h0, 64'hFFFF_FFFF_CAFE_BABE, 1'b0, 2, 1, 0, 64'h0);
    run_req("ld_w_u", 1'b0, SZ_W, 1'b0, 64'h00, 64'h0, 64'h0000_0000_0000_80FF, 1'b0, 2, 1, 0, 64'h0);
    run_req("st_d", 1'b1, SZ_D, 1'b0, 64'h18, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, 2, 0, 1, 64'hDEAD_BEEF_0123_4567);
    run_req("ld_b7_u", 1'b0, SZ_B, 1'b0, 64'h1F, 64'h0, 64'h0000_0000_0000_00DE, 1'b0, 2, 1, 0, 64'h0);
    run_req("ld_b7_s", 1'b0, SZ_B, 1'b1, 64'h1F, 64'h0, 64'hFFFF_FFFF_FFFF_FFDE, 1'b0, 2, 1, 0, 64'h0);
    run_req("mis_ld_w", 1'b0, SZ_W, 1'b0, 64'h02, 64'h0, 64'h0, 1'b1, 1, 0, 0, 64'h0);
    run_req("mis_st_h", 1'b1, SZ_H, 1'b0, 64'h13, 64'hFFFF, 64'h0, 1'b1, 1, 0, 0, 64'h0);
    check("mis_st_h:mem2", mem[2], 64'hAAAA_1234_AAAA_AAAA);
    run_req("mis_ld_d", 1'b0, SZ_D, 1'b0, 64'h0C, 64'h0, 64'h0, 1'b1, 1, 0, 0, 64'h0);
`ifdef MEM_ACCESS_UNIT_BOUNDS_CHECK_EN
    run_req("bounds", 1'b0, SZ_D, 1'b0, 64'h28, 64'h0, 64'h0, 1'b1, 1, 0, 0, 64'h0);
`else
    run_req("bounds", 1'b0, SZ_D, 1'b0, 64'h28, 64'h0, 64'h5555_0000_5555_0000, 1'b0, 2, 1, 0, 64'h0);
`endif

    // Reset lands in the RD cycle of a partial store; the write must never happen.
    @(negedge clock);
    req_write = 1'b1; req_size = SZ_B; req_signed = 1'b0; req_addr = 64'h11; req_wdata = 64'h77;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("rst_mid:in_rd", 64'(mem_read), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid:state", 64'(dbg_state), 64'(IDLE));
    n_w = 0; n_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) check("rst_mid:ready", 64'(req_ready), 64'd1);
      if (mem_write) n_w++;
      if (resp_valid) n_v++;
    end
    check("rst_mid:no_write", 64'(n_w), 64'd0);
    check("rst_mid:no_resp", 64'(n_v), 64'd0);
    check("rst_mid:mem2", mem[2], 64'hAAAA_1234_AAAA_AAAA);
    run_req("post_rst_ld", 1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 64'hAAAA_1234_AAAA_AAAA, 1'b0, 2, 1, 0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
